instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Encoder and program loader for the 16-bit Harvard core; the write-side counterpart of the instruction decoder.
- Accepts one instruction per handshake as opcode plus operand fields and packs it into the 32-bit instruction word format.
- Writes packed words sequentially into instruction memory through a request/grant port.
- Sits between the boot/debug loader and the instruction memory write port.

Parameters:
- IMEM_AW, 8, instruction-memory address width.
- IMEM_DEPTH, 256, number of words; the last writable address is IMEM_DEPTH-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- prog_start  in  1  pulse: open a load session at prog_base
- prog_base  in  IMEM_AW  first write address
- prog_end  in  1  pulse: close the session after any pending write completes
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept fields
- in_opcode  in  6  operation code
- in_rd2, in_rd1, in_rs2, in_rs1  in  5 each  register fields
- in_imm  in  16  immediate (MOV-immediate)
- in_addr  in  8  data address (LOAD source / STORE destination)
- imem_req  out  1  write request
- imem_gnt  in  1  memory accepted the write this cycle
- imem_addr  out  IMEM_AW  write address
- imem_wdata  out  32  packed instruction word
- busy  out  1  session open
- full  out  1  address space exhausted
- err_illegal  out  1  sticky: illegal opcode was dropped
- word_count  out  IMEM_AW+1  words written this session

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - Reset asserted mid-write drops the word, clears all state and deasserts imem_req asynchronously.
- Encoding. Word [31:26] = opcode; unused bits are 0.
  - 000000 MOV-imm: [25:21]=rd2, [15:0]=imm.
  - 000001 MOV-reg: [25:21]=rd2, [4:0]=rs2.
  - 000010 LOAD: [25:21]=rd2, [7:0]=addr.
  - 000011 STORE: [25:18]=addr, [4:0]=rs2.
  - 000100..010000 ALU ops (ADD, SUB, NEG, MUL, DIV, OR, XOR, NAND, NOR, XNOR, NOT, LLSH, LRSH): [25:21]=rd2, [20:16]=rd1, [9:5]=rs2, [4:0]=rs1.
  - Opcode > 010000 is illegal.
- States:
  - IDLE: busy=0, in_ready=0.
    - prog_start → LOAD; addr=prog_base; word_count=0; full=0; err_illegal=0.
  - LOAD: in_ready=1.
    - Handshake (in_valid & in_ready), legal opcode: word registered, → WRITE; imem_req=1 from the next cycle.
    - Handshake, illegal opcode: word dropped, err_illegal set, remain in LOAD.
    - prog_end → IDLE.
  - WRITE: in_ready=0; imem_req, imem_addr and imem_wdata held stable until imem_gnt.
    - On the gnt cycle: word_count+1 and imem_req drops next cycle.
    - After gnt: if addr==IMEM_DEPTH-1 → FULL; otherwise addr+1, → LOAD.
    - prog_end received in WRITE is latched; after gnt → IDLE instead of LOAD.
  - FULL: full=1, in_ready=0, busy=1.
    - prog_end → IDLE (full stays 1 until the next prog_start).
    - Address never wraps; no write past IMEM_DEPTH-1.
- Latency and throughput: accept at cycle N → imem_req at N+1. With gnt at N+1, in_ready is back at N+2, so one word per 2 cycles minimum.
- Simultaneous events:
  - prog_start outside IDLE is ignored.
  - prog_end together with a handshake in LOAD: the word is accepted and written, then → IDLE.
- word_count saturates at IMEM_DEPTH.

Optional Feature:
- Macro: ENC_CHECKSUM_EN.
- Defined:
  - Adds output checksum (32 bits): the running XOR of every granted imem_wdata.
  - Cleared on reset and on prog_start.
  - Updated in the gnt cycle, visible the following cycle.
- Undefined: no checksum port and no checksum logic.

Decomposition:
- Shared package isa_pkg:
  - Opcode constants (OP_MOVI through OP_LRSH).
  - Field bit positions and widths (OPC_MSB/LSB, RD2, RD1, RS2, RS1, IMM, LD_ADDR, ST_ADDR).
  - Typedef instr_word_t (32-bit).
  - The same package is reused by the decoder.
- Sub-module instr_field_pack: combinational fields → {word, illegal}, instantiated once.
- FSM, address counter and write port stay in the top.

Test Plan:
- ADD: prog_start, base=0x10; opcode 000100, rd2=3, rd1=4, rs2=5, rs1=6 → imem_wdata=0x106400A6 at addr 0x10; word_count=1.
- MOV-imm rd2=1, imm=0xBEEF → 0x0020BEEF. LOAD rd2=2, addr=0x33 → 0x08400033. STORE addr=0x5A, rs2=7 → 0x0D680007. Addresses increment by 1 per word.
- Grant stall: hold imem_gnt=0 for 5 cycles → req, addr and wdata stable; in_ready=0 throughout; word_count changes only on gnt.
- Illegal opcode 111111 → no imem_req, err_illegal=1, in_ready stays 1; the next legal word is written at the unchanged address.
- Full: base=0xFE, three words sent → writes at 0xFE and 0xFF only; full=1, in_ready=0; the third word is never accepted.
- Assert rst_n low during WRITE → imem_req=0 immediately, all outputs 0; the ENC_CHECKSUM_EN build shows checksum=0 after reset.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit Harvard core: opcodes, instruction
// word field positions, the instruction word type and the loader FSM states.
// The decoder imports this same package.
package isa_pkg;

   typedef logic [31:0] instr_word_t;
   typedef logic [5:0]  opcode_t;

   localparam opcode_t OP_MOVI  = 6'd0;
   localparam opcode_t OP_MOVR  = 6'd1;
   localparam opcode_t OP_LOAD  = 6'd2;
   localparam opcode_t OP_STORE = 6'd3;
   localparam opcode_t OP_ADD   = 6'd4;
   localparam opcode_t OP_SUB   = 6'd5;
   localparam opcode_t OP_NEG   = 6'd6;
   localparam opcode_t OP_MUL   = 6'd7;
   localparam opcode_t OP_DIV   = 6'd8;
   localparam opcode_t OP_OR    = 6'd9;
   localparam opcode_t OP_XOR   = 6'd10;
   localparam opcode_t OP_NAND  = 6'd11;
   localparam opcode_t OP_NOR   = 6'd12;
   localparam opcode_t OP_XNOR  = 6'd13;
   localparam opcode_t OP_NOT   = 6'd14;
   localparam opcode_t OP_LLSH  = 6'd15;
   localparam opcode_t OP_LRSH  = 6'd16;

   // Field bit positions inside instr_word_t
   localparam int OPC_MSB     = 31;
   localparam int OPC_LSB     = 26;
   localparam int RD2_MSB     = 25;
   localparam int RD2_LSB     = 21;
   localparam int RD1_MSB     = 20;
   localparam int RD1_LSB     = 16;
   localparam int RS2_MSB     = 9;
   localparam int RS2_LSB     = 5;
   localparam int RS1_MSB     = 4;
   localparam int RS1_LSB     = 0;
   // Single-source ops (MOV-reg, STORE) carry rs2 in the low slot
   localparam int RS2S_MSB    = 4;
   localparam int RS2S_LSB    = 0;
   localparam int IMM_MSB     = 15;
   localparam int IMM_LSB     = 0;
   localparam int LD_ADDR_MSB = 7;
   localparam int LD_ADDR_LSB = 0;
   localparam int ST_ADDR_MSB = 25;
   localparam int ST_ADDR_LSB = 18;

   localparam int REG_W  = 5;
   localparam int IMM_W  = 16;
   localparam int DADR_W = 8;

   // Loader session states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_FULL  = 2'd3
   } ldr_state_t;

   // Opcodes above the last ALU op are not part of the ISA
   function automatic logic opc_is_legal(input opcode_t op);
      return (op <= OP_LRSH);
   endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: opcode + operand fields -> 32-bit instruction word.
// Fields not used by an opcode are left zero; illegal opcodes yield a zero
// word with o_illegal set.
module instr_field_pack
   import isa_pkg::*;
(
   input  logic [5:0]        i_opcode,
   input  logic [REG_W-1:0]  i_rd2,
   input  logic [REG_W-1:0]  i_rd1,
   input  logic [REG_W-1:0]  i_rs2,
   input  logic [REG_W-1:0]  i_rs1,
   input  logic [IMM_W-1:0]  i_imm,
   input  logic [DADR_W-1:0] i_addr,
   output instr_word_t       o_word,
   output logic              o_illegal
);

   // Place each field according to the opcode class
   always_comb begin
      o_word    = '0;
      o_illegal = 1'b0;
      o_word[OPC_MSB:OPC_LSB] = i_opcode;
      case (i_opcode)
         OP_MOVI: begin
            o_word[RD2_MSB:RD2_LSB] = i_rd2;
            o_word[IMM_MSB:IMM_LSB] = i_imm;
         end
         OP_MOVR: begin
            o_word[RD2_MSB:RD2_LSB]   = i_rd2;
            o_word[RS2S_MSB:RS2S_LSB] = i_rs2;
         end
         OP_LOAD: begin
            o_word[RD2_MSB:RD2_LSB]         = i_rd2;
            o_word[LD_ADDR_MSB:LD_ADDR_LSB] = i_addr;
         end
         OP_STORE: begin
            o_word[ST_ADDR_MSB:ST_ADDR_LSB] = i_addr;
            o_word[RS2S_MSB:RS2S_LSB]       = i_rs2;
         end
         default: begin
            if (opc_is_legal(i_opcode)) begin
               o_word[RD2_MSB:RD2_LSB] = i_rd2;
               o_word[RD1_MSB:RD1_LSB] = i_rd1;
               o_word[RS2_MSB:RS2_LSB] = i_rs2;
               o_word[RS1_MSB:RS1_LSB] = i_rs1;
            end else begin
               o_word    = '0;
               o_illegal = 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder and program loader: packs one instruction per
// handshake and writes it sequentially into instruction memory through a
// request/grant port. Optional running XOR checksum of granted words is
// enabled with the ENC_CHECKSUM_EN macro.
module instr_encoder_loader
   import isa_pkg::*;
#(
   parameter int IMEM_AW    = 8,
   parameter int IMEM_DEPTH = 256
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               prog_start,
   input  logic [IMEM_AW-1:0] prog_base,
   input  logic               prog_end,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [5:0]         in_opcode,
   input  logic [4:0]         in_rd2,
   input  logic [4:0]         in_rd1,
   input  logic [4:0]         in_rs2,
   input  logic [4:0]         in_rs1,
   input  logic [15:0]        in_imm,
   input  logic [7:0]         in_addr,
   output logic               imem_req,
   input  logic               imem_gnt,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [31:0]        imem_wdata,
   output logic               busy,
   output logic               full,
   output logic               err_illegal,
   output logic [IMEM_AW:0]   word_count
`ifdef ENC_CHECKSUM_EN
   ,output logic [31:0]       checksum
`endif
);

   localparam logic [IMEM_AW-1:0] LAST_ADDR = IMEM_AW'(IMEM_DEPTH - 1);
   localparam logic [IMEM_AW:0]   COUNT_MAX = (IMEM_AW+1)'(IMEM_DEPTH);

   ldr_state_t         r_state;
   logic [IMEM_AW-1:0] r_addr;
   instr_word_t        r_wdata;
   logic               r_req;
   logic               r_busy;
   logic               r_in_ready;
   logic               r_full;
   logic               r_err;
   logic               r_end_pend;
   logic [IMEM_AW:0]   r_count;

   instr_word_t        w_word;
   logic               w_illegal;
   logic               w_hs;
   logic               w_last;
   logic               w_done;

   instr_field_pack u_pack (
      .i_opcode  (in_opcode),
      .i_rd2     (in_rd2),
      .i_rd1     (in_rd1),
      .i_rs2     (in_rs2),
      .i_rs1     (in_rs1),
      .i_imm     (in_imm),
      .i_addr    (in_addr),
      .o_word    (w_word),
      .o_illegal (w_illegal)
   );

   assign w_hs   = in_valid & r_in_ready;
   assign w_last = (r_addr == LAST_ADDR);
   // Session closes after this grant if prog_end was seen during the write
   assign w_done = r_end_pend | prog_end;

   // Session FSM, address counter and write port, all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_req      <= 1'b0;
         r_busy     <= 1'b0;
         r_in_ready <= 1'b0;
         r_full     <= 1'b0;
         r_err      <= 1'b0;
         r_end_pend <= 1'b0;
         r_count    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (prog_start) begin
                  r_state    <= ST_LOAD;
                  r_addr     <= prog_base;
                  r_count    <= '0;
                  r_full     <= 1'b0;
                  r_err      <= 1'b0;
                  r_end_pend <= 1'b0;
                  r_busy     <= 1'b1;
                  r_in_ready <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (w_hs && !w_illegal) begin
                  r_state    <= ST_WRITE;
                  r_wdata    <= w_word;
                  r_req      <= 1'b1;
                  r_in_ready <= 1'b0;
                  r_end_pend <= prog_end;
               end else begin
                  if (w_hs) begin
                     r_err <= 1'b1;
                  end
                  if (prog_end) begin
                     r_state    <= ST_IDLE;
                     r_busy     <= 1'b0;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            ST_WRITE: begin
               if (imem_gnt) begin
                  r_req      <= 1'b0;
                  r_end_pend <= 1'b0;
                  r_count    <= (r_count == COUNT_MAX) ? r_count : r_count + 1'b1;
                  if (w_last) begin
                     r_full <= 1'b1;
                  end else begin
                     r_addr <= r_addr + 1'b1;
                  end
                  if (w_done) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else if (w_last) begin
                     r_state <= ST_FULL;
                  end else begin
                     r_state    <= ST_LOAD;
                     r_in_ready <= 1'b1;
                  end
               end else if (prog_end) begin
                  r_end_pend <= 1'b1;
               end
            end
            ST_FULL: begin
               if (prog_end) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_req      <= 1'b0;
               r_busy     <= 1'b0;
               r_in_ready <= 1'b0;
            end
         endcase
      end
   end

`ifdef ENC_CHECKSUM_EN
   logic [31:0] r_checksum;

   // Running XOR of every granted word, restarted with each session
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_checksum <= '0;
      end else if ((r_state == ST_IDLE) && prog_start) begin
         r_checksum <= '0;
      end else if (r_req && imem_gnt) begin
         r_checksum <= r_checksum ^ r_wdata;
      end
   end

   assign checksum = r_checksum;
`endif

   assign in_ready    = r_in_ready;
   assign imem_req    = r_req;
   assign imem_addr   = r_addr;
   assign imem_wdata  = r_wdata;
   assign busy        = r_busy;
   assign full        = r_full;
   assign err_illegal = r_err;
   assign word_count  = r_count;

endmodule
